// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path.
// Segment order is {g,f,e,d,c,b,a}; all levels active-high.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = '0;

    // Entry 15 first: HEX_SEG[n] is the glyph for hex digit n.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to gfedcba segment decoder.
// Active-high segments; polarity is the consumer's concern.
module seg7_hex_decode
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg
);

    assign seg = HEX_SEG[digit];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit 7-segment scan driver with cursor blink.
// Define SEG_SCAN_DP_CURSOR_EN to mark the cursor slot with a steady dp.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 4,
    parameter int BLINK_DIV      = 12500000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] digit1,
    input  logic [DIGIT_W-1:0] digit2,
    input  logic [DIGIT_W-1:0] digit3,
    input  logic [DIGIT_W-1:0] digit4,
    input  logic [DIGIT_W-1:0] digit5,
    input  logic [DIGIT_W-1:0] digit6,
    input  logic [DIGIT_W-1:0] digit7,
    input  logic [DIGIT_W-1:0] digit8,
    input  logic [2:0]         position_pointer,
    input  logic               cursor_en,
    output logic [SEG_W-1:0]   seg,
    output logic               dp,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] GUARD_END  = SW'(GUARD);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    localparam logic [SEG_W-1:0]      SEG_INV = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_in;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] sh_digit;
    logic [IW-1:0]                      sh_ptr;
    logic                               sh_cursor;

    logic                  scan_wrap;
    logic                  in_guard;
    logic                  frame_start;
    logic                  on_cursor;
    logic [SEG_W-1:0]      dec_seg;
    logic [SEG_W-1:0]      seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic                  dp_nxt;

    assign digits_in = {digit8, digit7, digit6, digit5,
                        digit4, digit3, digit2, digit1};

    assign scan_wrap   = (scan_cnt == SCAN_LAST);
    assign in_guard    = (scan_cnt < GUARD_END);
    assign frame_start = (scan_cnt == '0) && (idx == '0);
    assign on_cursor   = (idx == sh_ptr);

    seg7_hex_decode u_dec (
        .digit (sh_digit[idx]),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            idx      <= idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Blink is free-running so the cursor phase never depends on scan timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digit  <= '0;
            sh_ptr    <= '0;
            sh_cursor <= 1'b0;
        end else if (frame_start) begin
            sh_digit  <= digits_in;
            sh_ptr    <= position_pointer;
            sh_cursor <= cursor_en;
        end
    end

    always_comb begin
        an_nxt  = '0;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b0;
        if (!in_guard) begin
            an_nxt[idx] = 1'b1;
            if (sh_cursor && on_cursor && !blink_on) begin
                seg_nxt = SEG_BLANK;
            end else begin
                seg_nxt = dec_seg;
            end
`ifdef SEG_SCAN_DP_CURSOR_EN
            dp_nxt = sh_cursor && on_cursor;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_INV;
            seg <= SEG_INV;
            dp  <= SEG_ACTIVE_LOW;
        end else begin
            an  <= an_nxt ^ AN_INV;
            seg <= seg_nxt ^ SEG_INV;
            dp  <= dp_nxt ^ SEG_ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: scan order, frame sampling,
// cursor blink, reset and both output polarities.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d [8];
    logic [2:0] ptr;
    logic       cen;

    logic [6:0] seg_h, seg_l;
    logic       dp_h, dp_l;
    logic [7:0] an_h, an_l;

    int passed = 0;
    int total  = 0;
    int k      = 0;

    logic [3:0] sh_d [8];
    logic [2:0] sh_p;
    logic       sh_e;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk = ~clk;

    seg_scan_driver #(
        .SCAN_DIV(4), .GUARD(1), .BLINK_DIV(16),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .digit1(d[0]), .digit2(d[1]), .digit3(d[2]), .digit4(d[3]),
        .digit5(d[4]), .digit6(d[5]), .digit7(d[6]), .digit8(d[7]),
        .position_pointer(ptr), .cursor_en(cen),
        .seg(seg_h), .dp(dp_h), .an(an_h)
    );

    seg_scan_driver #(
        .SCAN_DIV(4), .GUARD(1), .BLINK_DIV(16),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) u_pol (
        .clk(clk), .rst_n(rst_n),
        .digit1(d[0]), .digit2(d[1]), .digit3(d[2]), .digit4(d[3]),
        .digit5(d[4]), .digit6(d[5]), .digit7(d[6]), .digit8(d[7]),
        .position_pointer(ptr), .cursor_en(cen),
        .seg(seg_l), .dp(dp_l), .an(an_l)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle %0d: got %h expected %h",
                    tag, k, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp);
        logic [7:0] p_an;
        logic [6:0] p_seg;
        logic       p_dp;
        p_an  = ~e_an;
        p_seg = ~e_seg;
        p_dp  = ~e_dp;
        chk({tag, "_an"},     an_h,             e_an);
        chk({tag, "_seg"},    {1'b0, seg_h},    {1'b0, e_seg});
        chk({tag, "_dp"},     {7'b0, dp_h},     {7'b0, e_dp});
        chk({tag, "_an_n"},   an_l,             p_an);
        chk({tag, "_seg_n"},  {1'b0, seg_l},    {1'b0, p_seg});
        chk({tag, "_dp_n"},   {7'b0, dp_l},     {7'b0, p_dp});
    endtask

    // Output after edge k reflects state after k-1 edges since reset.
    task automatic step();
        int s, slot;
        logic on;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        @(posedge clk);
        #1;
        k++;
        s    = (k - 1) % 4;
        slot = ((k - 1) / 4) % 8;
        on   = (((k - 1) / 16) % 2) == 0;
        if ((k - 1) % 32 == 0) begin
            for (int i = 0; i < 8; i++) sh_d[i] = d[i];
            sh_p = ptr;
            sh_e = cen;
        end
        e_an  = 8'h00;
        e_seg = 7'h00;
        e_dp  = 1'b0;
        if (s != 0) begin
            e_an = 8'h01 << slot;
            e_seg = HEX[sh_d[slot]];
            if (sh_e && slot == int'(sh_p) && !on) e_seg = 7'h00;
`ifdef SEG_SCAN_DP_CURSOR_EN
            e_dp = sh_e && slot == int'(sh_p);
`endif
        end
        chk_all("scan", e_an, e_seg, e_dp);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = 4'(i + 1);
        ptr = 3'd0;
        cen = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 7'h00, 1'b0);

        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (k == 13) d[0] = 4'hA;
        end

        d[0] = 4'h8;
        d[2] = 4'h5;
        ptr  = 3'd2;
        cen  = 1'b1;
        for (int i = 0; i < 32; i++) step();

        ptr = 3'd6;
        for (int i = 0; i < 32; i++) step();

        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 7'h00, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk_all("rst_hold", 8'h00, 7'h00, 1'b0);
        cen = 1'b0;
        ptr = 3'd0;
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 8; i++) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
